// File: rtl/depth_ctrl_pkg.sv
// Shared types for the depth-control issue stage.
// Command layout and issue FSM encoding.
package depth_ctrl_pkg;

  localparam int CTRL_W = 7;
  localparam int RPT_W  = 4;

  typedef struct packed {
    logic [CTRL_W-1:0] word;
    logic [RPT_W-1:0]  rpt;
  } ctrl_cmd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } issue_state_t;

endpackage

// File: rtl/depth_ctrl_fifo.sv
// Command FIFO for the depth-control issue stage.
// Pointers carry one extra wrap bit for full/empty.
module depth_ctrl_fifo
  import depth_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  ctrl_cmd_t din,
  output ctrl_cmd_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  ctrl_cmd_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointer update; flush drops every queued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/depth_ctrl_issue.sv
// Issue stage: repeats each queued word rpt+1 times
// toward the depth-control decoder.
module depth_ctrl_issue
  import depth_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RPT_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_word,
  input  logic [RPT_W-1:0]  in_rpt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_word,
  output logic              out_last,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic              busy
);

  issue_state_t      state_q;
  issue_state_t      state_d;
  ctrl_cmd_t         push_cmd;
  ctrl_cmd_t         head;
  logic              full;
  logic              empty;
  logic              hs;
  logic              rem_zero;
  logic              pop;
  logic [RPT_W-1:0]  rem_q;
  logic [CTRL_W-1:0] word_q;
  logic              last_q;
  logic [CNT_W-1:0]  cnt_q;

  assign push_cmd.word = in_word;
  assign push_cmd.rpt  = in_rpt;

  assign in_ready  = !full;
  assign hs        = out_valid && out_ready;
  assign rem_zero  = (rem_q == '0);
  assign pop       = !flush && !empty &&
                     (state_q == IDLE || (hs && rem_zero));

  assign out_word  = word_q;
  assign out_last  = last_q;
  assign issue_cnt = cnt_q;
  assign busy      = !empty || out_valid;

  depth_ctrl_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .din   (push_cmd),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: leave ISSUE only when the last beat drains an empty FIFO.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty) state_d = ISSUE;
      ISSUE:   if (hs && rem_zero && empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // FSM outputs.
  always_comb begin
    out_valid = (state_q == ISSUE);
  end

  // Output register, repeat counter and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      rem_q  <= '0;
      last_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (hs && !flush) cnt_q <= cnt_q + CNT_W'(1);
      if (flush) begin
        last_q <= 1'b0;
      end else if (pop) begin
        word_q <= head.word;
        rem_q  <= head.rpt;
        last_q <= (head.rpt == '0);
      end else if (hs) begin
        if (!rem_zero) begin
          rem_q  <= rem_q - RPT_W'(1);
          last_q <= (rem_q == RPT_W'(1));
        end else begin
          last_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_depth_ctrl_issue.sv
// Bench for depth_ctrl_issue: vector table plus
// hand sequences for backpressure, flush, wrap and reset.
module tb_depth_ctrl_issue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_word;
  logic [3:0] in_rpt;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_word;
  logic       out_last;
  logic [3:0] issue_cnt;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  depth_ctrl_issue #(
    .DEPTH (4),
    .RPT_W (4),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_rpt    (in_rpt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_last  (out_last),
    .issue_cnt (issue_cnt),
    .busy      (busy)
  );

  typedef struct {
    logic       iv;
    logic [6:0] w;
    logic [3:0] r;
    logic       ordy;
    logic       fl;
    logic       ev;
    logic [6:0] ew;
    logic       el;
    logic [3:0] ec;
    logic       eir;
    logic       eb;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [6:0] w,
                       input logic [3:0] r, input logic ordy,
                       input logic fl);
    in_valid  = iv;
    in_word   = w;
    in_rpt    = r;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic v,
                         input logic [6:0] w, input logic l,
                         input logic [3:0] c, input logic ir,
                         input logic b);
    chk({nm, "_valid"}, 32'(out_valid), 32'(v));
    chk({nm, "_word"},  32'(out_word),  32'(w));
    chk({nm, "_last"},  32'(out_last),  32'(l));
    chk({nm, "_cnt"},   32'(issue_cnt), 32'(c));
    chk({nm, "_inrdy"}, 32'(in_ready),  32'(ir));
    chk({nm, "_busy"},  32'(busy),      32'(b));
  endtask

  int beats;
  int lasts;

  initial begin
    rst_n = 1'b0;
    drive(0, 7'h00, 4'h0, 0, 0);
    #12;
    chk_out("reset", 0, 7'h00, 0, 4'h0, 1, 0);
    rst_n = 1'b1;
    tick();

    // iv w r ordy fl | ev ew el ec eir eb
    // single word, rpt=0
    vq.push_back('{1, 7'h15, 4'd0, 1, 0, 0, 7'h00, 0, 4'd0, 1, 1});
    vq.push_back('{0, 7'h00, 4'd0, 1, 0, 1, 7'h15, 1, 4'd0, 1, 1});
    vq.push_back('{0, 7'h00, 4'd0, 1, 0, 0, 7'h15, 0, 4'd1, 1, 0});
    // 03 x3 then 40, no bubble
    vq.push_back('{1, 7'h03, 4'd2, 1, 0, 0, 7'h15, 0, 4'd1, 1, 1});
    vq.push_back('{1, 7'h40, 4'd0, 1, 0, 1, 7'h03, 0, 4'd1, 1, 1});
    vq.push_back('{0, 7'h00, 4'd0, 1, 0, 1, 7'h03, 0, 4'd2, 1, 1});
    vq.push_back('{0, 7'h00, 4'd0, 1, 0, 1, 7'h03, 1, 4'd3, 1, 1});
    vq.push_back('{0, 7'h00, 4'd0, 1, 0, 1, 7'h40, 1, 4'd4, 1, 1});
    vq.push_back('{0, 7'h00, 4'd0, 1, 0, 0, 7'h40, 0, 4'd5, 1, 0});
    // stall 5 cycles mid-repeat
    vq.push_back('{1, 7'h2A, 4'd2, 0, 0, 0, 7'h40, 0, 4'd5, 1, 1});
    vq.push_back('{0, 7'h00, 4'd0, 0, 0, 1, 7'h2A, 0, 4'd5, 1, 1});
    vq.push_back('{0, 7'h00, 4'd0, 1, 0, 1, 7'h2A, 0, 4'd6, 1, 1});
    for (int k = 0; k < 5; k++)
      vq.push_back('{0, 7'h00, 4'd0, 0, 0, 1, 7'h2A, 0, 4'd6, 1, 1});
    vq.push_back('{0, 7'h00, 4'd0, 1, 0, 1, 7'h2A, 1, 4'd7, 1, 1});
    vq.push_back('{0, 7'h00, 4'd0, 1, 0, 0, 7'h2A, 0, 4'd8, 1, 0});

    foreach (vq[i]) begin
      drive(vq[i].iv, vq[i].w, vq[i].r, vq[i].ordy, vq[i].fl);
      tick();
      chk_out($sformatf("v%0d", i), vq[i].ev, vq[i].ew, vq[i].el,
              vq[i].ec, vq[i].eir, vq[i].eb);
    end

    // backpressure: fill output register plus 4 FIFO entries
    for (int k = 0; k < 5; k++) begin
      drive(1, 7'(8'h11 + k), 4'd0, 0, 0);
      tick();
    end
    chk_out("bp_full", 1, 7'h11, 1, 4'd8, 0, 1);
    drive(1, 7'h16, 4'd0, 0, 0);
    tick();
    chk_out("bp_pend", 1, 7'h11, 1, 4'd8, 0, 1);
    drive(1, 7'h16, 4'd0, 1, 0);
    tick();
    chk_out("bp_pop1", 1, 7'h12, 1, 4'd9, 1, 1);
    tick();
    chk_out("bp_pop2", 1, 7'h13, 1, 4'd10, 1, 1);
    drive(0, 7'h00, 4'd0, 1, 0);
    tick();
    chk_out("bp_d14", 1, 7'h14, 1, 4'd11, 1, 1);
    tick();
    chk_out("bp_d15", 1, 7'h15, 1, 4'd12, 1, 1);
    tick();
    chk_out("bp_d16", 1, 7'h16, 1, 4'd13, 1, 1);
    tick();
    chk_out("bp_idle", 0, 7'h16, 0, 4'd14, 1, 0);

    // flush on 2nd beat of a rpt=3 word with 2 queued
    drive(1, 7'h33, 4'd3, 1, 0);
    tick();
    drive(1, 7'h44, 4'd0, 1, 0);
    tick();
    chk_out("fl_load", 1, 7'h33, 0, 4'd14, 1, 1);
    drive(1, 7'h55, 4'd0, 1, 0);
    tick();
    chk_out("fl_beat2", 1, 7'h33, 0, 4'd15, 1, 1);
    drive(1, 7'h66, 4'd0, 1, 1);
    tick();
    chk_out("fl_now", 0, 7'h33, 0, 4'd15, 1, 0);
    drive(0, 7'h00, 4'd0, 1, 0);
    tick();
    chk_out("fl_after", 0, 7'h33, 0, 4'd15, 1, 0);

    // counter wrap: 15 -> 0 -> 1
    drive(1, 7'h7F, 4'd1, 1, 0);
    tick();
    drive(0, 7'h00, 4'd0, 1, 0);
    tick();
    chk_out("wr_load", 1, 7'h7F, 0, 4'd15, 1, 1);
    tick();
    chk_out("wr_zero", 1, 7'h7F, 1, 4'd0, 1, 1);
    tick();
    chk_out("wr_one", 0, 7'h7F, 0, 4'd1, 1, 0);

    // rpt all-ones gives 16 beats, one last
    drive(1, 7'h01, 4'hF, 1, 0);
    tick();
    drive(0, 7'h00, 4'd0, 1, 0);
    beats = 0;
    lasts = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid) begin
        beats++;
        if (out_last) lasts++;
      end else if (beats > 0) begin
        break;
      end
    end
    chk("max_rpt_beats", 32'(beats), 32'd16);
    chk("max_rpt_lasts", 32'(lasts), 32'd1);
    chk("max_rpt_cnt", 32'(issue_cnt), 32'd1);

    // async reset mid-burst
    drive(1, 7'h0A, 4'd5, 1, 0);
    tick();
    drive(0, 7'h00, 4'd0, 1, 0);
    tick();
    tick();
    chk_out("rs_pre", 1, 7'h0A, 0, 4'd2, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rs_async", 0, 7'h00, 0, 4'd0, 1, 0);
    #2;
    rst_n = 1'b1;
    drive(1, 7'h0B, 4'd0, 1, 0);
    tick();
    chk_out("rs_push", 0, 7'h00, 0, 4'd0, 1, 1);
    drive(0, 7'h00, 4'd0, 1, 0);
    tick();
    chk_out("rs_issue", 1, 7'h0B, 1, 4'd0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/depth_ctrl_issue.md
Name: depth_ctrl_issue

Overview:
- Upstream issue stage for the depth-control decoder.
- Buffers 7-bit control words, each with a repeat count, in a small FIFO.
- Presents one word per beat on out_word, whose bits 0..6 drive decoder inputs x0..x6, using a valid/ready handshake.
- Re-issues each word (rpt+1) times, flags the final beat, and keeps a wrapping count of issued beats.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RPT_W, 4, width of the repeat field.
- CNT_W, 16, width of the issued-beat counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO and issue state.
- in_valid  in  1  upstream command valid.
- in_ready  out  1  FIFO can accept; equals ~full.
- in_word  in  7  control word; bit i maps to decoder input xi.
- in_rpt  in  RPT_W  extra repetitions; 0 = issue once.
- out_valid  out  1  out_word valid to decoder stage.
- out_ready  in  1  decoder stage accepts.
- out_word  out  7  registered control word.
- out_last  out  1  high on the final repetition of the current word.
- issue_cnt  out  CNT_W  count of out handshakes; wraps modulo 2^CNT_W.
- busy  out  1  FIFO non-empty or out_valid.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; FIFO empty; out_valid=0; out_word=0; out_last=0; issue_cnt=0; busy=0; in_ready=1.
- Push: occurs when in_valid & in_ready. There is no bypass, so a full FIFO never accepts, even if a pop occurs in the same cycle.
- FSM state IDLE:
  - out_valid=0.
  - If the FIFO is non-empty, pop the head, load word and rem=rpt into the output register, and go to ISSUE.
- FSM state ISSUE:
  - out_valid=1.
  - Handshake = out_valid & out_ready.
  - On a handshake with rem>0: rem decrements; out_word is unchanged.
  - On a handshake with rem==0 and the FIFO non-empty: pop and load the next command in the same cycle, staying in ISSUE. This gives back-to-back beats with no bubble.
  - On a handshake with rem==0 and the FIFO empty: go to IDLE; out_valid=0 next cycle.
  - Without a handshake: out_word, out_last and rem are held stable.
- out_last = out_valid & (rem==0), registered together with the output stage.
- Latency: a push in cycle 0 into an empty FIFO with an idle output gives out_valid=1 in cycle 2.
- Throughput: 1 beat/cycle while out_ready=1 and the FIFO is non-empty.
- Push and pop in the same cycle are both allowed; occupancy is unchanged, and is correct at count=1 and count=DEPTH-1.
- FIFO pointers are log2(DEPTH) bits plus 1 wrap bit:
  - full = pointers differ only in the wrap bit.
  - empty = pointers equal.
- issue_cnt increments by 1 on each handshake; all-ones +1 gives 0; there is no saturation.
- flush has highest priority over push, pop and handshake:
  - Next cycle: FIFO empty, state IDLE, out_valid=0, out_last=0.
  - A push or handshake coincident with flush is discarded and does not count.
  - issue_cnt is not cleared; out_word keeps its old value.
- Reset asserted mid-burst: all state clears immediately. No partial beat is visible after rst_n rises, and the first cycle after release accepts pushes.
- in_rpt of all-ones issues 2^RPT_W beats with no overflow; rem is RPT_W bits wide.

Decomposition:
- Package depth_ctrl_pkg:
  - CTRL_W=7.
  - typedef ctrl_cmd_t {word[CTRL_W-1:0], rpt[RPT_W-1:0]}.
  - typedef enum issue_state_t {IDLE, ISSUE}.
- Sub-module depth_ctrl_fifo: a synchronous FIFO of ctrl_cmd_t with push, pop, flush, full and empty.
- The top level contains the FSM, output register and counter.

Test Plan:
- Push word 7'h15 with rpt=0 into an idle block, out_ready=1 -> out_valid in cycle 2 with out_word=7'h15 and out_last=1 for exactly one cycle; issue_cnt=1; busy falls the cycle after.
- Push 7'h03 rpt=2, then 7'h40 rpt=0, out_ready=1 -> beats 03,03,03,40 on consecutive cycles with no bubble; out_last=1 on the 3rd and 4th beats; issue_cnt=4.
- out_ready=0 for 5 cycles mid-repeat -> out_word and out_last stable and issue_cnt unchanged; the sequence resumes intact.
- Hold out_ready=0 and push 5 commands with DEPTH=4 -> first command in the output register, the next 4 in the FIFO; in_ready=0 with the 6th command pending; in_ready rises the cycle after the first pop.
- Assert flush during the 2nd beat of a rpt=3 word with 2 commands queued -> next cycle out_valid=0 and busy=0; the coincident push is dropped; issue_cnt keeps its pre-flush value.
- Preload issue_cnt near 2^CNT_W-1 (CNT_W=4: issue 15 beats), then issue 2 more -> issue_cnt wraps to 1.
- Drop rst_n mid-burst -> all outputs go to their reset values asynchronously, before the next clock edge.
